dllp_ack_nak_decoder: RTL and testbench
=======================================

// Module: dllp_ack_nak_decoder
// PURPOSE
//  Receive-side DLLP decoder that feeds the replay buffer's ack_nack/seq inputs.
//  - Reassembles 6-byte DLLPs from a 16-bit stream and checks the CRC-16.
//  - Filters stale ACKs and issues one-cycle ack_nack pulses with the AckNak_Seq_Num.
//  - Sits between the receive lane deframer and replay_buffer.
// PARAMETERS
//  ACK_TYPE  8'h00  DLLP type byte decoded as ACK
//  NAK_TYPE  8'h10  DLLP type byte decoded as NAK
//  CNT_W     8      width of saturating statistics counters
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      asynchronous active-low reset
//  dllp_valid   in   1      dllp_data carries a word this cycle
//  dllp_sop     in   1      first word of a DLLP; qualified by dllp_valid
//  dllp_data    in   16     w0={type,rsvd}, w1={rsvd[3:0],seq[11:0]}, w2=CRC
//  ack_nack     out  2      01=ACK, 10=NAK, 00=idle; one-cycle pulse
//  seq          out  12     AckNak_Seq_Num; valid while ack_nack!=0, else holds
//  crc_err      out  1      one-cycle pulse on a DLLP dropped for bad CRC
//  ack_cnt      out  CNT_W  forwarded ACKs, saturating
//  nak_cnt      out  CNT_W  forwarded NAKs, saturating
//  drop_cnt     out  CNT_W  dropped DLLPs (CRC, stale, unknown type), saturating
// BEHAVIOUR
//  - Reset: every output 0; last_seq=12'hFFF; FSM=IDLE.
//  - FSM IDLE -> W1 -> W2 -> CHK -> IDLE.
//    - Advance only on dllp_valid; gaps with valid=0 hold the state.
//    - valid&sop in any state captures w0 and goes to W1, aborting any partial DLLP silently.
//    - valid&!sop in IDLE is ignored.
//  - CHK lasts one cycle and evaluates the captured DLLP.
//  - Outputs are registered at the end of CHK.
//    - ack_nack/crc_err are high on the clock after the CHK cycle.
//    - Latency from w2 accepted to pulse: 2 clocks.
//  - CRC: poly 16'h100B, seed 16'hFFFF, 4 content bytes MSB-first; w2 must equal ~crc.
//  - Decision order in CHK:
//    1. CRC bad -> crc_err=1, drop_cnt++.
//    2. Type not ACK/NAK -> drop_cnt++, no pulse.
//    3. NAK -> ack_nack=10, seq=s, last_seq=s, nak_cnt++ (always forwarded).
//    4. ACK with d=(s-last_seq) mod 4096 in 1..2047 -> ack_nack=01, seq=s, last_seq=s, ack_cnt++.
//    5. ACK otherwise (duplicate or stale) -> drop_cnt++, no pulse.
//  - Seq arithmetic is 12-bit modular; 12'hFFF -> 12'h000 is a forward step (d=1).
//  - A new sop during CHK is accepted; the CHK result still completes, so back-to-back DLLPs
//    every 3 valid cycles produce pulses with no loss.
//  - Counters stop at all-ones.
//  - Reset mid-DLLP discards partial state; no pulse is generated.
// CONFIGURATION
//  DLLP_CRC_CHECK_EN defined:
//    - CRC computed and checked as above.
//  DLLP_CRC_CHECK_EN undefined:
//    - No CRC logic; w2 is consumed but ignored.
//    - crc_err is tied 0 and every DLLP passes step 1.
// TESTING
//  1. Reset, then ACK s=12'h001 with good CRC -> ack_nack=01, seq=001 for exactly 1 clk,
//     2 clks after w2; ack_cnt=1.
//  2. NAK s=12'h002 after test 1 -> ack_nack=10, seq=002; nak_cnt=1; last_seq=002.
//  3. ACK s=12'h002 repeated, then ACK s=12'h001 -> no pulses; drop_cnt +2.
//  4. ACK with w2 bit0 flipped -> crc_err pulse, no ack_nack, drop_cnt+1
//     (with DLLP_CRC_CHECK_EN undefined: ACK forwarded instead).
//  5. Force last_seq=12'hFFE via ACKs, then ACK s=12'h001 -> forwarded (wrap, d=3).
//  6. sop at w0, valid low 3 clks, then sop restart with a new ACK s=12'h010
//     -> only the s=010 pulse appears.

Source files
------------

// File: rtl/dllp_ack_nak_decoder.sv
// dllp_ack_nak_decoder
// Receive-side DLLP decoder feeding the replay buffer's ack_nack/seq inputs.
// It rebuilds 6-byte DLLPs from a 16-bit word stream, optionally checks the
// CRC-16, drops stale or duplicate ACKs, and emits one-cycle ack_nack pulses.
//
// Build option: define DLLP_CRC_CHECK_EN to compute and check the CRC-16
// (poly 16'h100B, seed 16'hFFFF, 4 content bytes MSB-first, w2 == ~crc).
// Without it, w2 is consumed but ignored and crc_err is tied low.
//
// Stream handshake: there is no backpressure. A word is transferred on every
// rising edge where dllp_valid is high; dllp_sop marks the first word of a
// DLLP and is ignored while dllp_valid is low. A new sop always restarts
// reassembly, silently discarding any partial DLLP.
//
// fsm_state exposes the reassembly state (IDLE=0, W1=1, W2=2, CHK=3).

module dllp_ack_nak_decoder #(
    parameter logic [7:0]  ACK_TYPE = 8'h00,
    parameter logic [7:0]  NAK_TYPE = 8'h10,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dllp_valid,
    input  logic             dllp_sop,
    input  logic [15:0]      dllp_data,
    output logic [1:0]       ack_nack,
    output logic [11:0]      seq,
    output logic             crc_err,
    output logic [CNT_W-1:0] ack_cnt,
    output logic [CNT_W-1:0] nak_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W1   = 2'd1,
        ST_W2   = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  type_q;
    logic [11:0] seq_q;
    logic [11:0] last_seq;
    logic        crc_ok;
    logic [11:0] seq_delta;
    logic        ack_fresh;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

`ifdef DLLP_CRC_CHECK_EN
    logic [7:0]  rsvd0_q;
    logic [3:0]  rsvd1_q;
    logic [15:0] crc_rx_q;
    logic        crc_err_q;

    // Bit-serial CRC-16 over the 32 content bits, MSB first.
    function automatic logic [15:0] crc16_msb(input logic [31:0] msg);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ msg[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
            else                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign crc_ok  = (crc_rx_q == ~crc16_msb({type_q, rsvd0_q, rsvd1_q, seq_q}));
    assign crc_err = crc_err_q;
`else
    assign crc_ok  = 1'b1;
    assign crc_err = 1'b0;
`endif

    // Forward distance from the last accepted sequence number, modulo 4096;
    // an ACK is fresh when that distance lies in 1..2047.
    assign seq_delta = seq_q - last_seq;
    assign ack_fresh = (seq_delta != 12'd0) && !seq_delta[11];
    assign fsm_state = state;

    // Reassembly FSM plus the CHK-cycle decision with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            type_q   <= '0;
            seq_q    <= '0;
            last_seq <= 12'hFFF;
            ack_nack <= 2'b00;
            seq      <= '0;
            ack_cnt  <= '0;
            nak_cnt  <= '0;
            drop_cnt <= '0;
`ifdef DLLP_CRC_CHECK_EN
            rsvd0_q   <= '0;
            rsvd1_q   <= '0;
            crc_rx_q  <= '0;
            crc_err_q <= 1'b0;
`endif
        end else begin
            ack_nack <= 2'b00;
`ifdef DLLP_CRC_CHECK_EN
            crc_err_q <= 1'b0;
`endif
            // The captured DLLP is judged in CHK even if a new sop arrives now.
            if (state == ST_CHK) begin
                if (!crc_ok) begin
`ifdef DLLP_CRC_CHECK_EN
                    crc_err_q <= 1'b1;
`endif
                    drop_cnt <= sat_inc(drop_cnt);
                end else if (type_q == NAK_TYPE) begin
                    ack_nack <= 2'b10;
                    seq      <= seq_q;
                    last_seq <= seq_q;
                    nak_cnt  <= sat_inc(nak_cnt);
                end else if ((type_q == ACK_TYPE) && ack_fresh) begin
                    ack_nack <= 2'b01;
                    seq      <= seq_q;
                    last_seq <= seq_q;
                    ack_cnt  <= sat_inc(ack_cnt);
                end else begin
                    drop_cnt <= sat_inc(drop_cnt);
                end
            end

            if (dllp_valid && dllp_sop) begin
                type_q <= dllp_data[15:8];
`ifdef DLLP_CRC_CHECK_EN
                rsvd0_q <= dllp_data[7:0];
`endif
                state <= ST_W1;
            end else begin
                case (state)
                    ST_W1: begin
                        if (dllp_valid) begin
                            seq_q <= dllp_data[11:0];
`ifdef DLLP_CRC_CHECK_EN
                            rsvd1_q <= dllp_data[15:12];
`endif
                            state <= ST_W2;
                        end
                    end
                    ST_W2: begin
                        if (dllp_valid) begin
`ifdef DLLP_CRC_CHECK_EN
                            crc_rx_q <= dllp_data;
`endif
                            state <= ST_CHK;
                        end
                    end
                    ST_CHK:  state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dllp_ack_nak_decoder.sv
// tb_dllp_ack_nak_decoder
// Directed table vectors, hand sequences for gaps/aborts/reset, and random
// DLLP traffic checked against a behavioural model. Honours DLLP_CRC_CHECK_EN.

module tb_dllp_ack_nak_decoder;

    localparam logic [7:0] ACK_T = 8'h00;
    localparam logic [7:0] NAK_T = 8'h10;
    localparam int         CNT_MAX = 255;
    localparam int         EW = 47;   // {cycle[31:0], ack_nack[1:0], seq[11:0], crc_err}

    logic        clk;
    logic        reset_n;
    logic        dllp_valid;
    logic        dllp_sop;
    logic [15:0] dllp_data;
    logic [1:0]  ack_nack;
    logic [11:0] seq;
    logic        crc_err;
    logic [7:0]  ack_cnt;
    logic [7:0]  nak_cnt;
    logic [7:0]  drop_cnt;
    logic [1:0]  fsm_state;

    dllp_ack_nak_decoder #(.ACK_TYPE(ACK_T), .NAK_TYPE(NAK_T), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dllp_valid (dllp_valid),
        .dllp_sop   (dllp_sop),
        .dllp_data  (dllp_data),
        .ack_nack   (ack_nack),
        .seq        (seq),
        .crc_err    (crc_err),
        .ack_cnt    (ack_cnt),
        .nak_cnt    (nak_cnt),
        .drop_cnt   (drop_cnt),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int m_last, m_ack, m_nak, m_drop;

    function automatic int sat_add(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Byte-at-a-time CRC-16, MSB first, poly 0x100B, seed 0xFFFF.
    function automatic logic [15:0] ref_crc(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        int c;
        logic [7:0] bytes [4];
        bytes = '{b0, b1, b2, b3};
        c = 'hFFFF;
        for (int k = 0; k < 4; k++) begin
            c = c ^ (int'(bytes[k]) << 8);
            for (int j = 0; j < 8; j++) begin
                c = c << 1;
                if ((c & 'h10000) != 0) c = c ^ 'h1100B;
            end
        end
        return c[15:0];
    endfunction

    task automatic model_reset();
        m_last = 'hFFF;
        m_ack  = 0;
        m_nak  = 0;
        m_drop = 0;
    endtask

    task automatic model_dllp(input logic [7:0] t, input logic [11:0] s, input bit crc_good,
                              output logic [1:0] an, output logic ce);
        int d;
        an = 2'b00;
        ce = 1'b0;
        d  = (int'(s) - m_last + 4096) % 4096;
`ifdef DLLP_CRC_CHECK_EN
        if (!crc_good) begin
            ce = 1'b1;
            m_drop = sat_add(m_drop);
        end else
`endif
        if (t == NAK_T) begin
            an = 2'b10; m_last = int'(s); m_nak = sat_add(m_nak);
        end else if (t == ACK_T && d >= 1 && d <= 2047) begin
            an = 2'b01; m_last = int'(s); m_ack = sat_add(m_ack);
        end else begin
            m_drop = sat_add(m_drop);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [EW-1:0] exp_q[$];
    logic [11:0]   mon_hold = 12'h000;
    bit            mon_en = 1'b0;

    // Every sampled cycle: either a scheduled DLLP result or idle with seq held.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset_n && mon_en) begin
            if (exp_q.size() > 0 && exp_q[0][46:15] < 32'(cyc)) begin
                e = exp_q.pop_front();
                chk("missed_result", 32'(cyc), e[46:15]);
            end
            if (exp_q.size() > 0 && exp_q[0][46:15] == 32'(cyc)) begin
                e = exp_q.pop_front();
                chk("pulse_ack_nack", 32'(ack_nack), 32'(e[14:13]));
                chk("pulse_crc_err", 32'(crc_err), 32'(e[0]));
                if (e[14:13] != 2'b00) mon_hold = e[12:1];
                chk("pulse_seq", 32'(seq), 32'(mon_hold));
            end else begin
                chk("idle_ack_nack", 32'(ack_nack), 32'd0);
                chk("idle_crc_err", 32'(crc_err), 32'd0);
                chk("idle_seq_hold", 32'(seq), 32'(mon_hold));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_word(input logic [15:0] d, input logic sop, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            @(posedge clk); #1;
            dllp_valid = 1'b0;
            dllp_sop   = 1'($urandom_range(1, 0));
            dllp_data  = 16'($urandom);
        end
        @(posedge clk); #1;
        dllp_valid = 1'b1;
        dllp_sop   = sop;
        dllp_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            dllp_valid = 1'b0;
            dllp_sop   = 1'b0;
        end
    endtask

    task automatic send_dllp(input logic [7:0] t, input logic [11:0] s, input logic [15:0] flip,
                             input int max_gap, input bit use_tab,
                             input logic [1:0] tab_an, input logic tab_ce);
        logic [7:0]  r0;
        logic [3:0]  r1;
        logic [15:0] good;
        logic [1:0]  an;
        logic        ce;
        int          c2;
        r0   = 8'($urandom);
        r1   = 4'($urandom);
        good = ~ref_crc(t, r0, {r1, s[11:8]}, s[7:0]);
        drive_word({t, r0}, 1'b1, max_gap);
        drive_word({r1, s}, 1'b0, max_gap);
        drive_word(good ^ flip, 1'b0, max_gap);
        c2 = cyc;
        model_dllp(t, s, (flip == 16'h0000), an, ce);
        if (use_tab) begin
            an = tab_an;
            ce = tab_ce;
        end
        exp_q.push_back({32'(c2 + 2), an, s, ce});
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_ack_cnt"},  32'(ack_cnt),  32'(m_ack));
        chk({tag, "_nak_cnt"},  32'(nak_cnt),  32'(m_nak));
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack_nack"}, 32'(ack_nack), 32'd0);
        chk({tag, "_seq"},      32'(seq),      32'd0);
        chk({tag, "_crc_err"},  32'(crc_err),  32'd0);
        chk({tag, "_ack_cnt"},  32'(ack_cnt),  32'd0);
        chk({tag, "_nak_cnt"},  32'(nak_cnt),  32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0]  t;
        logic [11:0] s;
        logic [15:0] flip;
        logic [1:0]  an;
        logic        ce;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{ACK_T, 12'h001, 16'h0000, 2'b01, 1'b0};
        vecs[1]  = '{NAK_T, 12'h002, 16'h0000, 2'b10, 1'b0};
        vecs[2]  = '{ACK_T, 12'h002, 16'h0000, 2'b00, 1'b0};
        vecs[3]  = '{ACK_T, 12'h001, 16'h0000, 2'b00, 1'b0};
`ifdef DLLP_CRC_CHECK_EN
        vecs[4]  = '{ACK_T, 12'h003, 16'h0001, 2'b00, 1'b1};
`else
        vecs[4]  = '{ACK_T, 12'h003, 16'h0001, 2'b01, 1'b0};
`endif
        vecs[5]  = '{ACK_T, 12'h800, 16'h0000, 2'b01, 1'b0};
        vecs[6]  = '{ACK_T, 12'hFFE, 16'h0000, 2'b01, 1'b0};
        vecs[7]  = '{ACK_T, 12'h001, 16'h0000, 2'b01, 1'b0};
        vecs[8]  = '{8'h20, 12'h005, 16'h0000, 2'b00, 1'b0};
        vecs[9]  = '{NAK_T, 12'h000, 16'h0000, 2'b10, 1'b0};
        vecs[10] = '{ACK_T, 12'h801, 16'h0000, 2'b00, 1'b0};
        vecs[11] = '{ACK_T, 12'h7FF, 16'h0000, 2'b01, 1'b0};

        reset_n    = 1'b0;
        dllp_valid = 1'b0;
        dllp_sop   = 1'b0;
        dllp_data  = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        // Tests 1-5, back to back.
        for (int i = 0; i < 9; i++)
            send_dllp(vecs[i].t, vecs[i].s, vecs[i].flip, 0, 1'b1, vecs[i].an, vecs[i].ce);
        idle(4);
`ifdef DLLP_CRC_CHECK_EN
        chk("dir_a_ack_cnt", 32'(ack_cnt), 32'd4);
        chk("dir_a_drop_cnt", 32'(drop_cnt), 32'd4);
`else
        chk("dir_a_ack_cnt", 32'(ack_cnt), 32'd5);
        chk("dir_a_drop_cnt", 32'(drop_cnt), 32'd3);
`endif
        chk("dir_a_nak_cnt", 32'(nak_cnt), 32'd1);

        // Test 6: abandoned w0, 3 idle clocks, sop restart with ACK 010.
        drive_word({ACK_T, 8'h00}, 1'b1, 0);
        idle(3);
        send_dllp(ACK_T, 12'h010, 16'h0000, 0, 1'b1, 2'b01, 1'b0);
        idle(4);

        // NAK always forwarded; ACK window edges d=0x801 (drop) and d=0x7FF.
        for (int i = 9; i < 12; i++)
            send_dllp(vecs[i].t, vecs[i].s, vecs[i].flip, 1, 1'b1, vecs[i].an, vecs[i].ce);
        idle(4);
`ifdef DLLP_CRC_CHECK_EN
        chk("dir_b_ack_cnt", 32'(ack_cnt), 32'd6);
        chk("dir_b_drop_cnt", 32'(drop_cnt), 32'd5);
`else
        chk("dir_b_ack_cnt", 32'(ack_cnt), 32'd7);
        chk("dir_b_drop_cnt", 32'(drop_cnt), 32'd4);
`endif
        chk("dir_b_nak_cnt", 32'(nak_cnt), 32'd2);
        check_counters("dir_b");

        // Reset in the middle of a DLLP, then a stray non-sop word in IDLE.
        drive_word({ACK_T, 8'h00}, 1'b1, 0);
        drive_word(16'h0123, 1'b0, 0);
        @(posedge clk); #1;
        dllp_valid = 1'b0;
        mon_en     = 1'b0;
        reset_n    = 1'b0;
        #2;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        reset_n  = 1'b1;
        model_reset();
        mon_hold = 12'h000;
        mon_en   = 1'b1;
        drive_word(16'hABCD, 1'b0, 0);
        idle(4);
        // 0xFFF -> 0x000 is a forward step.
        send_dllp(ACK_T, 12'h000, 16'h0000, 0, 1'b1, 2'b01, 1'b0);
        idle(4);
        check_counters("post_reset");

        // Random traffic with gaps, aborts, bad CRCs and stale ACKs.
        for (int n = 0; n < 250; n++) begin
            logic [7:0]  t;
            logic [11:0] s;
            logic [15:0] fl;
            int          r;
            r = int'($urandom_range(9, 0));
            if (r <= 5)      t = ACK_T;
            else if (r <= 8) t = NAK_T;
            else begin
                t = 8'($urandom_range(255, 1));
                if (t == NAK_T) t = 8'h11;
            end
            case ($urandom_range(3, 0))
                0:       s = 12'(m_last + int'($urandom_range(3, 0)));
                1:       s = 12'(m_last + 2047 + int'($urandom_range(1, 0)));
                default: s = 12'($urandom);
            endcase
            fl = ($urandom_range(7, 0) == 0) ? (16'h0001 << $urandom_range(15, 0)) : 16'h0000;
            if ($urandom_range(7, 0) == 0) begin
                drive_word({ACK_T, 8'h5A}, 1'b1, 1);
                if ($urandom_range(1, 0) == 1) drive_word(16'($urandom), 1'b0, 1);
            end
            send_dllp(t, s, fl, 2, 1'b0, 2'b00, 1'b0);
        end
        idle(4);
        check_counters("random");

        // Saturation: NAKs are always forwarded, so nak_cnt must stop at 0xFF.
        for (int n = 0; n < 260; n++)
            send_dllp(NAK_T, 12'($urandom), 16'h0000, 0, 1'b0, 2'b00, 1'b0);
        idle(4);
        chk("sat_nak_cnt", 32'(nak_cnt), 32'hFF);
        check_counters("sat");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
